// File: rtl/uart_password_top.sv
// UART password gate: 8N1 receiver and transmitter, prompt, password compare, GRANTED/DENIED report.
// Optional feature macro UART_ECHO_EN: echo '*' for every accepted password byte.
module uart_password_top #(
    parameter int          DELAY_FRAMES = 234,
    parameter int          PASS_LEN     = 4,
    parameter logic [31:0] PASSWORD     = "1a2B"
) (
    input  logic       clk,
    input  logic       btn,
    input  logic       uartRx,
    output logic       uartTx,
    output logic [5:0] led
);
    localparam int               CNT_W      = $clog2(DELAY_FRAMES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [2:0]       COUNT_LAST = 3'(PASS_LEN - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {SEQ_PROMPT, SEQ_COLLECT, SEQ_REPORT, SEQ_DONE} seq_state_t;

    // ---------------- receiver ----------------
    logic             r_rx_sync1, r_rx_sync2;
    rx_state_t        r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]       r_rx_bit, w_rx_bit_next;
    logic [7:0]       r_rx_shift, w_rx_shift_next;
    logic             r_rx_valid, w_rx_valid_next;

    always_ff @(posedge clk) begin
        if (!btn) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_sync1 <= uartRx;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_valid <= w_rx_valid_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + 1'b1;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_valid_next = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                if (!r_rx_sync2) w_rx_state_next = RX_START;
            end
            RX_START: begin
                // A start bit that is gone by mid-bit is treated as a glitch
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bit_next   = '0;
                    w_rx_state_next = r_rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {r_rx_sync2, r_rx_shift[7:1]};
                    w_rx_bit_next   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_valid_next = r_rx_sync2;
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    tx_state_t        r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]       r_tx_bit, w_tx_bit_next;
    logic [7:0]       r_tx_data, w_tx_data_next;
    logic             r_tx_line, w_tx_line_next;
    logic             w_tx_load;
    logic             w_src_valid;
    logic [7:0]       w_src_byte;

    always_ff @(posedge clk) begin
        if (!btn) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_data  <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_line  <= w_tx_line_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + 1'b1;
        w_tx_bit_next   = r_tx_bit;
        w_tx_data_next  = r_tx_data;
        w_tx_load       = 1'b0;
        w_tx_line_next  = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next = '0;
                if (w_src_valid) begin
                    w_tx_load       = 1'b1;
                    w_tx_data_next  = w_src_byte;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_bit_next   = '0;
                    w_tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_next = '0;
                    w_tx_bit_next = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit when another byte is waiting
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_next = '0;
                    if (w_src_valid) begin
                        w_tx_load       = 1'b1;
                        w_tx_data_next  = w_src_byte;
                        w_tx_state_next = TX_START;
                    end else begin
                        w_tx_state_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
        case (w_tx_state_next)
            TX_START: w_tx_line_next = 1'b0;
            TX_DATA:  w_tx_line_next = w_tx_data_next[w_tx_bit_next];
            default:  w_tx_line_next = 1'b1;
        endcase
    end

    assign uartTx = r_tx_line;

    // ---------------- sequencer ----------------
    seq_state_t r_seq_state, w_seq_state_next;
    logic [3:0] r_msg_ptr, w_msg_ptr_next;
    logic [2:0] r_rx_count, w_rx_count_next;
    logic       r_fail, w_fail_next;
    logic       r_granted, w_granted_next;
    logic       r_denied, w_denied_next;
    logic [7:0] w_msg_byte;
    logic [3:0] w_msg_last;
    logic       w_msg_active;
    logic       w_msg_take;
    logic       w_accept;
    logic       w_mismatch;
    logic [7:0] w_pass_bytes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_pass
        assign w_pass_bytes[gi] = PASSWORD[31 - 8 * gi -: 8];
    end

    always_comb begin
        w_msg_byte   = 8'h00;
        w_msg_last   = 4'd0;
        w_msg_active = 1'b0;
        case (r_seq_state)
            SEQ_PROMPT: begin
                w_msg_active = 1'b1;
                w_msg_last   = 4'd10;
                case (r_msg_ptr)
                    4'd0:    w_msg_byte = "P";
                    4'd1:    w_msg_byte = "a";
                    4'd2:    w_msg_byte = "s";
                    4'd3:    w_msg_byte = "s";
                    4'd4:    w_msg_byte = "w";
                    4'd5:    w_msg_byte = "o";
                    4'd6:    w_msg_byte = "r";
                    4'd7:    w_msg_byte = "d";
                    4'd8:    w_msg_byte = ":";
                    4'd9:    w_msg_byte = 8'h0D;
                    default: w_msg_byte = 8'h0A;
                endcase
            end
            SEQ_REPORT: begin
                w_msg_active = 1'b1;
                if (r_denied) begin
                    w_msg_last = 4'd7;
                    case (r_msg_ptr)
                        4'd0:    w_msg_byte = "D";
                        4'd1:    w_msg_byte = "E";
                        4'd2:    w_msg_byte = "N";
                        4'd3:    w_msg_byte = "I";
                        4'd4:    w_msg_byte = "E";
                        4'd5:    w_msg_byte = "D";
                        4'd6:    w_msg_byte = 8'h0D;
                        default: w_msg_byte = 8'h0A;
                    endcase
                end else begin
                    w_msg_last = 4'd8;
                    case (r_msg_ptr)
                        4'd0:    w_msg_byte = "G";
                        4'd1:    w_msg_byte = "R";
                        4'd2:    w_msg_byte = "A";
                        4'd3:    w_msg_byte = "N";
                        4'd4:    w_msg_byte = "T";
                        4'd5:    w_msg_byte = "E";
                        4'd6:    w_msg_byte = "D";
                        4'd7:    w_msg_byte = 8'h0D;
                        default: w_msg_byte = 8'h0A;
                    endcase
                end
            end
            default: w_msg_active = 1'b0;
        endcase
    end

`ifdef UART_ECHO_EN
    logic r_echo_pending, w_echo_pending_next;

    // A pending echo jumps ahead of message bytes, so the report follows the last '*'
    assign w_src_valid = r_echo_pending | w_msg_active;
    assign w_src_byte  = r_echo_pending ? 8'h2A : w_msg_byte;
    assign w_msg_take  = w_tx_load & ~r_echo_pending;

    always_comb begin
        w_echo_pending_next = r_echo_pending;
        if (w_tx_load && r_echo_pending) w_echo_pending_next = 1'b0;
        if (w_accept) w_echo_pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!btn) r_echo_pending <= 1'b0;
        else      r_echo_pending <= w_echo_pending_next;
    end
`else
    assign w_src_valid = w_msg_active;
    assign w_src_byte  = w_msg_byte;
    assign w_msg_take  = w_tx_load;
`endif

    assign w_accept   = r_rx_valid && (r_seq_state == SEQ_PROMPT || r_seq_state == SEQ_COLLECT);
    assign w_mismatch = (r_rx_shift != w_pass_bytes[r_rx_count[1:0]]);

    always_comb begin
        w_seq_state_next = r_seq_state;
        w_msg_ptr_next   = r_msg_ptr;
        w_rx_count_next  = r_rx_count;
        w_fail_next      = r_fail;
        w_granted_next   = r_granted;
        w_denied_next    = r_denied;
        if (w_msg_take) begin
            if (r_msg_ptr == w_msg_last) begin
                w_msg_ptr_next   = 4'd0;
                w_seq_state_next = (r_seq_state == SEQ_PROMPT) ? SEQ_COLLECT : SEQ_DONE;
            end else begin
                w_msg_ptr_next = r_msg_ptr + 4'd1;
            end
        end
        // Reaching the full count overrides prompt progress; the byte in flight still completes
        if (w_accept) begin
            w_rx_count_next = r_rx_count + 3'd1;
            w_fail_next     = r_fail | w_mismatch;
            if (r_rx_count == COUNT_LAST) begin
                w_seq_state_next = SEQ_REPORT;
                w_msg_ptr_next   = 4'd0;
                w_granted_next   = ~(r_fail | w_mismatch);
                w_denied_next    = r_fail | w_mismatch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!btn) begin
            r_seq_state <= SEQ_PROMPT;
            r_msg_ptr   <= 4'd0;
            r_rx_count  <= 3'd0;
            r_fail      <= 1'b0;
            r_granted   <= 1'b0;
            r_denied    <= 1'b0;
        end else begin
            r_seq_state <= w_seq_state_next;
            r_msg_ptr   <= w_msg_ptr_next;
            r_rx_count  <= w_rx_count_next;
            r_fail      <= w_fail_next;
            r_granted   <= w_granted_next;
            r_denied    <= w_denied_next;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_led
        assign led[gi] = ~(r_rx_count > 3'(gi));
    end
    assign led[4] = ~r_granted;
    assign led[5] = ~r_denied;

endmodule

// File: tb/tb_uart_password_top.sv
// Randomized bench for uart_password_top at 2 clk/bit: decodes uartTx and checks it and the LEDs
// against a message-level model of prompt, password compare, optional echo and report.
module tb_uart_password_top;
    localparam int DF       = 2;
    localparam int PASS_LEN = 4;

    logic       clk = 1'b0;
    logic       btn;
    logic       uartRx;
    logic       uartTx;
    logic [5:0] led;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pw [4] = '{8'h31, 8'h61, 8'h32, 8'h42};
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] acc_q [$];
    logic [5:0] exp_led;
    int         ev_kind [$];
    logic [7:0] ev_byte [$];

    uart_password_top #(
        .DELAY_FRAMES(DF),
        .PASS_LEN    (PASS_LEN),
        .PASSWORD    ("1a2B")
    ) dut (
        .clk   (clk),
        .btn   (btn),
        .uartRx(uartRx),
        .uartTx(uartTx),
        .led   (led)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame decoder on uartTx: every bit must hold for both of its clock cycles
    initial begin
        forever begin
            logic [19:0] s;
            logic        aborted;
            logic        fmt_ok;
            logic [7:0]  b;
            @(negedge clk);
            if (btn === 1'b1 && uartTx === 1'b0) begin
                s = '0;
                aborted = 1'b0;
                for (int i = 1; i < 20; i++) begin
                    @(negedge clk);
                    if (btn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = uartTx;
                end
                if (!aborted) begin
                    fmt_ok = (s[1:0] == 2'b00) && (s[19:18] == 2'b11);
                    for (int k = 0; k < 8; k++) begin
                        b[k] = s[2 + 2 * k];
                        if (s[2 + 2 * k] != s[3 + 2 * k]) fmt_ok = 1'b0;
                    end
                    check("tx_frame_fmt", 32'(fmt_ok), 32'd1);
                    got_q.push_back(b);
                end
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Reference: expected TX text and LEDs given the bytes that arrived with valid framing
    task automatic build_expect();
        int   n_acc;
        logic bad;
        n_acc = (acc_q.size() < PASS_LEN) ? acc_q.size() : PASS_LEN;
        bad = 1'b0;
        for (int i = 0; i < n_acc; i++) if (acc_q[i] != pw[i]) bad = 1'b1;
        exp_q.delete();
        push_str("Password:");
        push_crlf();
`ifdef UART_ECHO_EN
        for (int i = 0; i < n_acc; i++) exp_q.push_back(8'h2A);
`endif
        if (n_acc == PASS_LEN) begin
            if (bad) push_str("DENIED");
            else     push_str("GRANTED");
            push_crlf();
        end
        for (int i = 0; i < 4; i++) exp_led[i] = !(i < n_acc);
        exp_led[4] = !(n_acc == PASS_LEN && !bad);
        exp_led[5] = !(n_acc == PASS_LEN && bad);
    endtask

    task automatic compare_tx();
        check("tx_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("tx_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uartRx = frame[i];
            tick(DF);
        end
        uartRx = 1'b1;
        tick(4);
    endtask

    task automatic send_glitch();
        uartRx = 1'b0;
        tick(1);
        uartRx = 1'b1;
        tick(6);
    endtask

    task automatic start_session();
        btn = 1'b0;
        uartRx = 1'b1;
        tick(3);
        @(negedge clk);
        check("rst_tx", 32'(uartTx), 32'd1);
        check("rst_led", 32'(led), 32'h3F);
        tick(1);
        got_q.delete();
        acc_q.delete();
        btn = 1'b1;
        tick(240);
        build_expect();
        compare_tx();
        check("led_after_prompt", 32'(led), 32'h3F);
    endtask

    // kind 0: good frame, 1: stop bit 0 (dropped), 2: one-clock low glitch
    task automatic run_trial();
        start_session();
        for (int e = 0; e < ev_kind.size(); e++) begin
            case (ev_kind[e])
                0: begin
                    send_frame(ev_byte[e], 1'b1);
                    acc_q.push_back(ev_byte[e]);
                end
                1:       send_frame(ev_byte[e], 1'b0);
                default: send_glitch();
            endcase
            tick(4);
            build_expect();
            check($sformatf("led_ev%0d", e), 32'(led), 32'(exp_led));
        end
        tick(320);
        build_expect();
        compare_tx();
        check("led_final", 32'(led), 32'(exp_led));
    endtask

    task automatic add_ev(input int kind, input logic [7:0] b);
        ev_kind.push_back(kind);
        ev_byte.push_back(b);
    endtask

    initial begin
        int         n_ev;
        int         r;
        logic [7:0] b;
        btn = 1'b0;
        uartRx = 1'b1;

        // Correct password, then a fifth byte that must be ignored
        ev_kind.delete(); ev_byte.delete();
        add_ev(0, 8'h31); add_ev(0, 8'h61); add_ev(0, 8'h32); add_ev(0, 8'h42); add_ev(0, 8'h5A);
        run_trial();

        // Wrong last byte
        ev_kind.delete(); ev_byte.delete();
        add_ev(0, 8'h31); add_ev(0, 8'h61); add_ev(0, 8'h32); add_ev(0, 8'h32);
        run_trial();

        // Glitch and framing error are not counted, then a good password
        ev_kind.delete(); ev_byte.delete();
        add_ev(2, 8'h00); add_ev(1, 8'h31);
        add_ev(0, 8'h31); add_ev(0, 8'h61); add_ev(0, 8'h32); add_ev(0, 8'h42);
        run_trial();

        // Reset while the prompt is on the line
        btn = 1'b0;
        tick(3);
        got_q.delete();
        btn = 1'b1;
        tick(41);
        btn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", 32'(uartTx), 32'd1);
        check("midrst_led", 32'(led), 32'h3F);
        tick(1);
        got_q.delete();
        acc_q.delete();
        btn = 1'b1;
        tick(240);
        build_expect();
        compare_tx();

        // Randomized sessions
        for (int t = 0; t < 6; t++) begin
            ev_kind.delete(); ev_byte.delete();
            n_ev = $urandom_range(3, 7);
            for (int i = 0; i < n_ev; i++) begin
                r = $urandom_range(0, 9);
                b = ($urandom_range(0, 3) != 0) ? pw[i % 4] : 8'($urandom);
                add_ev((r < 7) ? 0 : ((r < 8) ? 1 : 2), b);
            end
            run_trial();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
